// File: rtl/mips_program_mem_pkg.sv
// Shared types for the 8-bit multicycle MIPS core and its program memory.
// Controller states, opcodes and the memory loader state live here.
package mips_program_mem_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd1,
    FETCH2  = 4'd2,
    FETCH3  = 4'd3,
    FETCH4  = 4'd4,
    DECODE  = 4'd5,
    MEMADR  = 4'd6,
    LBRD    = 4'd7,
    LBWR    = 4'd8,
    SBWR    = 4'd9,
    RTYPEEX = 4'd10,
    RTYPEWR = 4'd11,
    BEQEX   = 4'd12,
    JEX     = 4'd13,
    ADDIWR  = 4'd14
  } statetype;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode_t;

  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    RELEASE,
    RUN
  } memstate;

  localparam int MEM_WIDTH      = 8;
  localparam int MEM_DEPTH_BITS = 5;

endpackage

// File: rtl/mips_program_mem_if.sv
// Loader stream, core memory port and store observation signals.
// master: loader + core side, slave: the memory block.
interface mips_program_mem_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 5
);
  logic                  load_valid;
  logic [WIDTH-1:0]      load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_start;
  logic [DEPTH_BITS:0]   load_count;
  logic                  cpu_reset;
  logic [WIDTH-1:0]      cpu_adr;
  logic                  cpu_memread;
  logic                  cpu_memwrite;
  logic [WIDTH-1:0]      cpu_writedata;
  logic [WIDTH-1:0]      cpu_memdata;
  logic                  store_seen;
  logic [WIDTH-1:0]      store_adr;
  logic [WIDTH-1:0]      store_data;

  modport master (
    output load_valid, load_data, load_last, load_start,
    output cpu_adr, cpu_memread, cpu_memwrite, cpu_writedata,
    input  load_ready, load_count, cpu_reset, cpu_memdata,
    input  store_seen, store_adr, store_data
  );

  modport slave (
    input  load_valid, load_data, load_last, load_start,
    input  cpu_adr, cpu_memread, cpu_memwrite, cpu_writedata,
    output load_ready, load_count, cpu_reset, cpu_memdata,
    output store_seen, store_adr, store_data
  );
endinterface

// File: rtl/mips_bytemem.sv
// Byte array with async clear, one sync write port, one comb read port.
// Reads return the pre-edge contents on a same-address write.
module mips_bytemem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [DEPTH_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**DEPTH_BITS; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_program_mem.sv
// Program/data memory for the 8-bit MIPS core with a byte-stream loader
// that holds the core in reset until the program is in place.
module mips_program_mem
  import mips_program_mem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_program_mem_if.slave bus
);

  localparam logic [DEPTH_BITS:0] FULL =
    (DEPTH_BITS+1)'(2**DEPTH_BITS);

  memstate               r_state;
  logic [DEPTH_BITS-1:0] r_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_load_ready;
  logic                  r_cpu_reset;
  logic                  r_store_seen;
  logic [WIDTH-1:0]      r_store_adr;
  logic [WIDTH-1:0]      r_store_data;

  logic                  w_load_fire;
  logic                  w_cpu_we;
  logic                  w_ptr_end;
  logic                  w_we;
  logic [DEPTH_BITS-1:0] w_waddr;
  logic [WIDTH-1:0]      w_wdata;
  logic [DEPTH_BITS-1:0] w_raddr;

  assign w_load_fire = (r_state == LOAD) & bus.load_valid;
  assign w_cpu_we    = (r_state == RUN) & bus.cpu_memwrite;
  assign w_ptr_end   = (r_ptr == '1);
  assign w_raddr     = bus.cpu_adr[DEPTH_BITS-1:0];

  // Loader owns the write port in LOAD, the core in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_raddr;
    w_wdata = bus.cpu_writedata;
    unique case (1'b1)
      w_load_fire: begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
        w_wdata = bus.load_data;
      end
      w_cpu_we: w_we = 1'b1;
      default: ;
    endcase
  end

  mips_bytemem #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (bus.cpu_memdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_ptr        <= '0;
      r_count      <= '0;
      r_load_ready <= 1'b1;
      r_cpu_reset  <= 1'b1;
      r_store_seen <= 1'b0;
      r_store_adr  <= '0;
      r_store_data <= '0;
    end else begin
      r_store_seen <= w_cpu_we;
      if (w_cpu_we) begin
        r_store_adr  <= bus.cpu_adr;
        r_store_data <= bus.cpu_writedata;
      end
      unique case (r_state)
        LOAD: begin
          if (w_load_fire) begin
            r_ptr <= r_ptr + DEPTH_BITS'(1);
            if (r_count != FULL)
              r_count <= r_count + (DEPTH_BITS+1)'(1);
            // Stop at the top so a long stream never wraps over the start.
            if (bus.load_last || w_ptr_end) begin
              r_state      <= RELEASE;
              r_load_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          r_state     <= RUN;
          r_cpu_reset <= 1'b0;
        end
        RUN: begin
          if (bus.load_start) begin
            r_state      <= LOAD;
            r_ptr        <= '0;
            r_count      <= '0;
            r_load_ready <= 1'b1;
            r_cpu_reset  <= 1'b1;
          end
        end
        default: begin
          r_state      <= LOAD;
          r_load_ready <= 1'b1;
          r_cpu_reset  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.load_count = r_count;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.store_seen = r_store_seen;
  assign bus.store_adr  = r_store_adr;
  assign bus.store_data = r_store_data;

endmodule

// File: tb/tb_mips_program_mem.sv
// Directed bench for mips_program_mem: load, run, store capture,
// reload, overflow stop and asynchronous reset.
module tb_mips_program_mem;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] exp;
  } rd_vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rd_vec_t t_load4[$];
  rd_vec_t t_store[$];
  rd_vec_t t_reload[$];
  rd_vec_t t_full[$];
  rd_vec_t t_clear[$];

  mips_program_mem_if #(.WIDTH(8), .DEPTH_BITS(5)) bus ();

  mips_program_mem #(.WIDTH(8), .DEPTH_BITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_reads(input string tag, input rd_vec_t q[$]);
    foreach (q[i]) begin
      @(negedge clk);
      bus.cpu_adr = q[i].adr;
      #2;
      chk($sformatf("%s rd %0h", tag, q[i].adr),
          32'(bus.cpu_memdata), 32'(q[i].exp));
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    t_load4  = '{'{8'h00, 8'h20}, '{8'h01, 8'h05}, '{8'h02, 8'h00},
                 '{8'h03, 8'h80}, '{8'h04, 8'h00}};
    t_store  = '{'{8'h07, 8'hA5}, '{8'h27, 8'hA5}, '{8'h00, 8'h20}};
    t_reload = '{'{8'h00, 8'hAA}, '{8'h01, 8'hBB}, '{8'h02, 8'h00},
                 '{8'h03, 8'h80}, '{8'h07, 8'hA5}, '{8'h0A, 8'h3C}};
    t_full   = '{'{8'h00, 8'h00}, '{8'h05, 8'h05}, '{8'h10, 8'h10},
                 '{8'h1F, 8'h1F}, '{8'h3F, 8'h1F}, '{8'hE3, 8'h03}};
    t_clear  = '{'{8'h00, 8'h00}, '{8'h01, 8'h00}, '{8'h1F, 8'h00}};

    rst_n             = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.load_last     = 1'b0;
    bus.load_start    = 1'b0;
    bus.cpu_adr       = '0;
    bus.cpu_memread   = 1'b0;
    bus.cpu_memwrite  = 1'b0;
    bus.cpu_writedata = '0;
    #12;
    chk("rst load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst load_count", 32'(bus.load_count), 32'd0);
    chk("rst store_seen", 32'(bus.store_seen), 32'd0);
    chk("rst memdata", 32'(bus.cpu_memdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four-byte program ending with load_last
    load_byte(8'h20, 1'b0);
    load_byte(8'h05, 1'b0);
    load_byte(8'h00, 1'b0);
    load_byte(8'h80, 1'b1);
    chk("p4 count", 32'(bus.load_count), 32'd4);
    chk("p4 release ready", 32'(bus.load_ready), 32'd0);
    chk("p4 release cpu_reset", 32'(bus.cpu_reset), 32'd1);
    @(posedge clk);
    #1;
    chk("p4 run cpu_reset", 32'(bus.cpu_reset), 32'd0);
    chk("p4 run ready", 32'(bus.load_ready), 32'd0);
    apply_reads("p4", t_load4);

    // Aliased store, with the old byte visible before the edge
    @(negedge clk);
    bus.cpu_memwrite  = 1'b1;
    bus.cpu_adr       = 8'h27;
    bus.cpu_writedata = 8'hA5;
    #2;
    chk("rdw old byte", 32'(bus.cpu_memdata), 32'h00);
    @(posedge clk);
    #1;
    bus.cpu_memwrite = 1'b0;
    chk("st seen", 32'(bus.store_seen), 32'd1);
    chk("st adr", 32'(bus.store_adr), 32'h27);
    chk("st data", 32'(bus.store_data), 32'hA5);
    @(posedge clk);
    #1;
    chk("st seen drop", 32'(bus.store_seen), 32'd0);
    apply_reads("st", t_store);

    // load_valid held in RUN does nothing
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("run valid count", 32'(bus.load_count), 32'd4);
    bus.cpu_adr = 8'h00;
    #1;
    chk("run valid mem0", 32'(bus.cpu_memdata), 32'h20);
    bus.load_valid = 1'b0;

    // load_start together with a store on the same edge
    @(negedge clk);
    bus.load_start    = 1'b1;
    bus.cpu_memwrite  = 1'b1;
    bus.cpu_adr       = 8'h0A;
    bus.cpu_writedata = 8'h3C;
    @(posedge clk);
    #1;
    bus.load_start   = 1'b0;
    bus.cpu_memwrite = 1'b0;
    chk("ls cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("ls ready", 32'(bus.load_ready), 32'd1);
    chk("ls count", 32'(bus.load_count), 32'd0);
    chk("ls store_seen", 32'(bus.store_seen), 32'd1);
    bus.cpu_adr = 8'h03;
    #1;
    chk("ls retained", 32'(bus.cpu_memdata), 32'h80);
    load_byte(8'hAA, 1'b0);
    load_byte(8'hBB, 1'b1);
    chk("rl count", 32'(bus.load_count), 32'd2);
    @(posedge clk);
    #1;
    chk("rl run", 32'(bus.cpu_reset), 32'd0);
    apply_reads("rl", t_reload);

    // Full 32-byte stream with no load_last
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(i);
      bus.load_last  = 1'b0;
      @(posedge clk);
      #1;
      if (i == 30)
        chk("full ready 31st", 32'(bus.load_ready), 32'd1);
    end
    bus.load_data = 8'hEE;
    chk("full count", 32'(bus.load_count), 32'd32);
    chk("full ready", 32'(bus.load_ready), 32'd0);
    chk("full release", 32'(bus.cpu_reset), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("full run", 32'(bus.cpu_reset), 32'd0);
    chk("full no 33rd", 32'(bus.load_count), 32'd32);
    bus.load_valid = 1'b0;
    apply_reads("full", t_full);

    // Async reset in the middle of a load
    pulse_start();
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    chk("ml count", 32'(bus.load_count), 32'd3);
    chk("ml store_adr", 32'(bus.store_adr), 32'h0A);
    bus.cpu_adr = 8'h00;
    #1;
    chk("ml mem0", 32'(bus.cpu_memdata), 32'h11);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar count", 32'(bus.load_count), 32'd0);
    chk("ar cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("ar ready", 32'(bus.load_ready), 32'd1);
    chk("ar mem0", 32'(bus.cpu_memdata), 32'h00);
    chk("ar store_seen", 32'(bus.store_seen), 32'd0);
    chk("ar store_adr", 32'(bus.store_adr), 32'd0);
    chk("ar store_data", 32'(bus.store_data), 32'd0);
    apply_reads("ar", t_clear);
    @(negedge clk);
    rst_n = 1'b1;
    load_byte(8'h44, 1'b1);
    chk("ar reload count", 32'(bus.load_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
